serial_addsub: RTL and testbench
================================

// Module: serial_addsub
// PURPOSE
//   Parametrised multi-cycle adder/subtractor built from chained full-adder cells.
//   Each cycle it processes BITS_PER_CYCLE operand bits, LSB first, through a registered carry.
//   start/busy/done handshake. Used where area beats latency: slow datapaths, accumulators, demos.
// PARAMETERS
//   WIDTH           8   operand/result width in bits; must be >= 2
//   BITS_PER_CYCLE  1   bits resolved per RUN cycle; must divide WIDTH (elaboration error otherwise)
// PORTS
//   clk        in   1      single clock, all state on rising edge
//   rst_n      in   1      reset; synchronous and active-low
//   start      in   1      request; sampled only in IDLE or DONE
//   sub        in   1      0 = a+b, 1 = a-b; sampled with start
//   a          in   WIDTH  operand A; sampled with start
//   b          in   WIDTH  operand B; sampled with start
//   busy       out  1      high while RUN
//   done       out  1      one-cycle pulse: sum/carry_out valid and updated
//   sum        out  WIDTH  result, modulo 2^WIDTH; holds until next done
//   carry_out  out  1      carry out of MSB; for sub, 1 = no borrow
//   overflow   out  1      signed overflow; present only with SERIAL_ADDSUB_OVF_EN
// BEHAVIOUR
//   Reset (rst_n=0 at edge): state=IDLE; busy, done, sum, carry_out, overflow = 0.
//     Takes priority over everything. Mid-RUN reset aborts the operation with no done pulse.
//   States:
//     IDLE -start-> RUN
//     RUN: count STEPS = WIDTH/BITS_PER_CYCLE cycles, then -> DONE
//     DONE: one cycle -> IDLE, or -> RUN if start=1 (back-to-back)
//   On accept:
//     opA <= a; opB <= sub ? ~b : b; carry reg <= sub (two's-complement +1).
//     step counter <= 0; result shift register cleared.
//   RUN cycle:
//     BITS_PER_CYCLE full-adder cells add the low slices of opA/opB plus the carry reg.
//     Slice result shifts into the result register from the MSB end.
//     opA/opB shift right by BITS_PER_CYCLE; carry reg <= cell chain carry.
//   Timing: start accepted at edge k.
//     busy=1 for cycles k+1 .. k+STEPS.
//     done=1 in cycle k+STEPS+1; sum/carry_out update at that same edge.
//   start in RUN is ignored, with no queueing. Operands may change freely after acceptance.
//   sum and carry_out change only on the edge that raises done.
//   The result reflects exactly the operands sampled at accept.
//   No combinational path from inputs to outputs.
// CONFIGURATION
//   SERIAL_ADDSUB_OVF_EN defined: overflow port exists.
//     Registered with done as carry-into-MSB XOR carry-out-of-MSB. Reset 0.
//   Undefined: no overflow port and no MSB-carry capture logic.
// STRUCTURE
//   Package serial_addsub_pkg:
//     state enum {IDLE, RUN, DONE}
//     function steps(WIDTH, BITS_PER_CYCLE)
//     step-counter width via $clog2
//   Sub-module fa_cell: 1-bit full adder from two half-adder stages plus OR.
//     Instantiated BITS_PER_CYCLE times in a generate loop, carry chained.
// TESTING
//   W=8,B=1: a=0x5A, b=0x3C, sub=0 -> busy 8 cycles; done at k+9; sum=0x96, carry_out=0.
//   W=8,B=1: a=0x10, b=0x01, sub=1 -> sum=0x0F, carry_out=1.
//     Then 0x00-0x01 back-to-back (start during done) -> sum=0xFF, carry_out=0.
//   W=8,B=4: a=0xFF, b=0x01, sub=0 -> busy 2 cycles; done at k+3; sum=0x00, carry_out=1.
//   Pulse start with new operands mid-RUN -> ignored; result matches first operands; one done only.
//   rst_n=0 at RUN cycle 3 -> next cycle busy=0, done=0, sum=0; no done pulse.
//     A fresh start then completes normally.
//   OVF_EN, W=8: 0x7F+0x01 -> overflow=1, sum=0x80.
//     0x80-0x01 -> overflow=1, sum=0x7F.
//     0x05+0x03 -> overflow=0.

Source files
------------

// File: rtl/serial_addsub_pkg.sv
// Shared types and sizing helpers for the serial adder/subtractor.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Number of RUN cycles needed to walk an operand of width w, b bits at a time.
  function automatic int steps(input int w, input int b);
    return w / b;
  endfunction

  // Step-counter width; a single-step configuration still needs one bit.
  function automatic int cnt_width(input int s);
    return (s > 1) ? $clog2(s) : 1;
  endfunction

endpackage

// File: rtl/serial_addsub_fa_cell.sv
// One-bit full adder built from two half-adder stages and an OR of their carries.
module fa_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  logic p;
  logic g_ab;
  logic g_pc;

  // First half adder on the operands, second on the partial sum and carry-in.
  always_comb begin
    p    = a_i ^ b_i;
    g_ab = a_i & b_i;
    s_o  = p ^ c_i;
    g_pc = p & c_i;
    c_o  = g_ab | g_pc;
  end

endmodule

// File: rtl/serial_addsub.sv
// Multi-cycle adder/subtractor: BITS_PER_CYCLE operand bits per RUN cycle, LSB
// first, through a registered carry. Optional signed-overflow output is built
// when the macro SERIAL_ADDSUB_OVF_EN is defined.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDSUB_OVF_EN
  output logic             overflow,
`endif
  output logic             carry_out
);

  localparam int B     = BITS_PER_CYCLE;
  localparam int STEPS = steps(WIDTH, BITS_PER_CYCLE);
  localparam int CW    = cnt_width(STEPS);

  if (WIDTH < 2 || B < 1 || (WIDTH % B) != 0) begin : g_bad_cfg
    $error("serial_addsub: WIDTH must be >= 2 and a multiple of BITS_PER_CYCLE");
  end

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cy_q, cy_d;
  logic             cout_q, cout_d;
  logic [B-1:0]     slice_s;
  logic [B:0]       chain_c;
  logic [WIDTH+B-1:0] res_cat;
  logic             accept;
  logic             last;

  // Carry chain across this cycle's slice, seeded by the registered carry.
  assign chain_c[0] = cy_q;
  for (genvar gi = 0; gi < B; gi++) begin : g_cell
    fa_cell u_fa (
      .a_i (opa_q[gi]),
      .b_i (opb_q[gi]),
      .c_i (chain_c[gi]),
      .s_o (slice_s[gi]),
      .c_o (chain_c[gi+1])
    );
  end

  // New slice enters the result from the MSB end; older slices slide down.
  assign res_cat = {slice_s, res_q};
  assign accept  = start && (state_q == IDLE || state_q == DONE);
  assign last    = (state_q == RUN) && (cnt_q == CW'(STEPS - 1));

  // Next state, step count and result capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    unique case (state_q)
      IDLE: if (accept) state_d = RUN;
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          state_d = DONE;
          sum_d   = res_cat[WIDTH+B-1:B];
          cout_d  = chain_c[B];
        end
      end
      DONE: state_d = accept ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
    if (accept) cnt_d = '0;
  end

  // Operand load on accept, shift-and-add while running.
  always_comb begin
    opa_d = opa_q;
    opb_d = opb_q;
    res_d = res_q;
    cy_d  = cy_q;
    if (accept) begin
      opa_d = a;
      opb_d = sub ? ~b : b;
      cy_d  = sub;
      res_d = '0;
    end else if (state_q == RUN) begin
      opa_d = opa_q >> B;
      opb_d = opb_q >> B;
      cy_d  = chain_c[B];
      res_d = res_cat[WIDTH+B-1:B];
    end
  end

  // Control and visible result registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  // Datapath working registers carry no reset; they are reloaded on every accept.
  always_ff @(posedge clk) begin
    opa_q <= opa_d;
    opb_q <= opb_d;
    res_q <= res_d;
    cy_q  <= cy_d;
  end

`ifdef SERIAL_ADDSUB_OVF_EN
  logic ovf_q, ovf_d;

  // Signed overflow: carry into the MSB cell disagrees with carry out of it.
  always_comb begin
    ovf_d = ovf_q;
    if (last) ovf_d = chain_c[B] ^ chain_c[B-1];
  end

  // Overflow flag updates together with sum.
  always_ff @(posedge clk) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign overflow = ovf_q;
`endif

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign sum       = sum_q;
  assign carry_out = cout_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: one 8-bit/1-bit-per-cycle instance and
// one 8-bit/4-bits-per-cycle instance, checked against an arithmetic model.
// Overflow checks are active when SERIAL_ADDSUB_OVF_EN is defined.
module tb_serial_addsub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       s1, sub1, s4, sub4;
  logic [7:0] a1, b1, a4, b4;
  logic       busy1, done1, cout1, busy4, done4, cout4;
  logic [7:0] sum1, sum4;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic       ovf1, ovf4;
  logic       prev_o1, prev_o4;
`endif

  int tests = 0;
  int fails = 0;

  logic [7:0] prev_sum1, prev_sum4;
  logic       prev_c1, prev_c4;

  serial_addsub #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(s1), .sub(sub1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .sum(sum1),
`ifdef SERIAL_ADDSUB_OVF_EN
    .overflow(ovf1),
`endif
    .carry_out(cout1)
  );

  serial_addsub #(.WIDTH(8), .BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(s4), .sub(sub4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .sum(sum4),
`ifdef SERIAL_ADDSUB_OVF_EN
    .overflow(ovf4),
`endif
    .carry_out(cout4)
  );

  // Reference: integer arithmetic, {carry_out, sum}.
  function automatic logic [8:0] model_res(input logic [7:0] a, input logic [7:0] b, input logic s);
    int r;
    logic c;
    logic [7:0] v;
    r = s ? (int'(a) - int'(b)) : (int'(a) + int'(b));
    v = 8'(r);
    c = s ? (r >= 0) : (r > 255);
    return {c, v};
  endfunction

  function automatic logic model_ovf(input logic [7:0] a, input logic [7:0] b, input logic s);
    int sa, sb, r;
    sa = int'($signed(a));
    sb = int'($signed(b));
    r = s ? (sa - sb) : (sa + sb);
    return (r > 127) || (r < -128);
  endfunction

  // One full operation; caller is at a negedge. Returns at the done negedge.
  task automatic do_op(input bit w4, input logic [7:0] a, input logic [7:0] b, input logic s, input string nm);
    int steps;
    logic [8:0] exp;
    logic eo;
    logic bz, dn, co;
    logic [7:0] sm, ps;
    steps = w4 ? 2 : 8;
    exp = model_res(a, b, s);
    eo = model_ovf(a, b, s);
    if (w4) begin s4 = 1'b1; a4 = a; b4 = b; sub4 = s; end
    else    begin s1 = 1'b1; a1 = a; b1 = b; sub1 = s; end
    @(posedge clk);
    #1;
    if (w4) begin s4 = 1'b0; a4 = 8'($urandom); b4 = 8'($urandom); sub4 = 1'($urandom); end
    else    begin s1 = 1'b0; a1 = 8'($urandom); b1 = 8'($urandom); sub1 = 1'($urandom); end
    for (int i = 1; i <= steps; i++) begin
      @(negedge clk);
      bz = w4 ? busy4 : busy1;
      dn = w4 ? done4 : done1;
      sm = w4 ? sum4 : sum1;
      ps = w4 ? prev_sum4 : prev_sum1;
      tests++;
      if (bz !== 1'b1 || dn !== 1'b0) begin
        fails++;
        $display("FAIL %s run cycle %0d: busy=%b done=%b, required busy=1 done=0", nm, i, bz, dn);
      end
      tests++;
      if (sm !== ps) begin
        fails++;
        $display("FAIL %s sum hold cycle %0d: got %h, required %h", nm, i, sm, ps);
      end
    end
    @(negedge clk);
    bz = w4 ? busy4 : busy1;
    dn = w4 ? done4 : done1;
    sm = w4 ? sum4 : sum1;
    co = w4 ? cout4 : cout1;
    tests++;
    if (dn !== 1'b1 || bz !== 1'b0) begin
      fails++;
      $display("FAIL %s done cycle: busy=%b done=%b, required busy=0 done=1", nm, bz, dn);
    end
    tests++;
    if (sm !== exp[7:0] || co !== exp[8]) begin
      fails++;
      $display("FAIL %s result: sum=%h carry=%b, required sum=%h carry=%b", nm, sm, co, exp[7:0], exp[8]);
    end
`ifdef SERIAL_ADDSUB_OVF_EN
    tests++;
    if ((w4 ? ovf4 : ovf1) !== eo) begin
      fails++;
      $display("FAIL %s overflow: got %b, required %b", nm, (w4 ? ovf4 : ovf1), eo);
    end
    if (w4) prev_o4 = eo; else prev_o1 = eo;
`else
    if (eo === 1'bx) $display("model overflow unknown");
`endif
    if (w4) begin prev_sum4 = exp[7:0]; prev_c4 = exp[8]; end
    else    begin prev_sum1 = exp[7:0]; prev_c1 = exp[8]; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (busy1 !== 1'b0 || done1 !== 1'b0 || sum1 !== 8'h00 || cout1 !== 1'b0) begin
      fails++;
      $display("FAIL reset dut1: busy=%b done=%b sum=%h carry=%b, required all zero", busy1, done1, sum1, cout1);
    end
    tests++;
    if (busy4 !== 1'b0 || done4 !== 1'b0 || sum4 !== 8'h00 || cout4 !== 1'b0) begin
      fails++;
      $display("FAIL reset dut4: busy=%b done=%b sum=%h carry=%b, required all zero", busy4, done4, sum4, cout4);
    end
`ifdef SERIAL_ADDSUB_OVF_EN
    tests++;
    if (ovf1 !== 1'b0 || ovf4 !== 1'b0) begin
      fails++;
      $display("FAIL reset overflow: got %b/%b, required 0/0", ovf1, ovf4);
    end
    prev_o1 = 1'b0; prev_o4 = 1'b0;
`endif
    prev_sum1 = 8'h00; prev_sum4 = 8'h00; prev_c1 = 1'b0; prev_c4 = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add_directed();
    do_op(1'b0, 8'h5A, 8'h3C, 1'b0, "add_5A_3C");
    tests++;
    if (sum1 !== 8'h96 || cout1 !== 1'b0) begin
      fails++;
      $display("FAIL add_5A_3C const: sum=%h carry=%b, required 96/0", sum1, cout1);
    end
    @(negedge clk);
  endtask

  task automatic test_sub_back_to_back();
    do_op(1'b0, 8'h10, 8'h01, 1'b1, "sub_10_01");
    tests++;
    if (sum1 !== 8'h0F || cout1 !== 1'b1) begin
      fails++;
      $display("FAIL sub_10_01 const: sum=%h carry=%b, required 0F/1", sum1, cout1);
    end
    do_op(1'b0, 8'h00, 8'h01, 1'b1, "sub_b2b_00_01");
    tests++;
    if (sum1 !== 8'hFF || cout1 !== 1'b0) begin
      fails++;
      $display("FAIL sub_b2b const: sum=%h carry=%b, required FF/0", sum1, cout1);
    end
    @(negedge clk);
  endtask

  task automatic test_bpc4();
    do_op(1'b1, 8'hFF, 8'h01, 1'b0, "bpc4_FF_01");
    tests++;
    if (sum4 !== 8'h00 || cout4 !== 1'b1) begin
      fails++;
      $display("FAIL bpc4 const: sum=%h carry=%b, required 00/1", sum4, cout4);
    end
    @(negedge clk);
  endtask

  task automatic test_start_ignored();
    int nd;
    logic [7:0] cs;
    logic cc;
    nd = 0; cs = 8'h00; cc = 1'b0;
    s1 = 1'b1; a1 = 8'h21; b1 = 8'h13; sub1 = 1'b0;
    @(posedge clk);
    #1 s1 = 1'b0;
    repeat (3) @(negedge clk);
    s1 = 1'b1; a1 = 8'hF0; b1 = 8'hF0; sub1 = 1'b1;
    @(negedge clk);
    s1 = 1'b0;
    repeat (14) begin
      @(negedge clk);
      if (done1 === 1'b1) begin nd++; cs = sum1; cc = cout1; end
    end
    tests++;
    if (nd != 1) begin
      fails++;
      $display("FAIL start_ignored done count: got %0d, required 1", nd);
    end
    tests++;
    if (cs !== 8'h34 || cc !== 1'b0) begin
      fails++;
      $display("FAIL start_ignored result: sum=%h carry=%b, required 34/0", cs, cc);
    end
    prev_sum1 = 8'h34; prev_c1 = 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
    prev_o1 = 1'b0;
`endif
  endtask

  task automatic test_mid_reset();
    int nd;
    nd = 0;
    s1 = 1'b1; a1 = 8'h77; b1 = 8'h11; sub1 = 1'b0;
    @(posedge clk);
    #1 s1 = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (busy1 !== 1'b1) begin
      fails++;
      $display("FAIL mid_reset pre: busy=%b, required 1", busy1);
    end
    rst_n = 1'b0;
    @(negedge clk);
    tests++;
    if (busy1 !== 1'b0 || done1 !== 1'b0 || sum1 !== 8'h00 || cout1 !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset post: busy=%b done=%b sum=%h carry=%b, required 0/0/00/0", busy1, done1, sum1, cout1);
    end
    rst_n = 1'b1;
    prev_sum1 = 8'h00; prev_sum4 = 8'h00; prev_c1 = 1'b0; prev_c4 = 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
    prev_o1 = 1'b0; prev_o4 = 1'b0;
`endif
    repeat (12) begin
      @(negedge clk);
      if (done1 === 1'b1) nd++;
    end
    tests++;
    if (nd != 0) begin
      fails++;
      $display("FAIL mid_reset stray done: got %0d pulses, required 0", nd);
    end
    do_op(1'b0, 8'h77, 8'h11, 1'b0, "post_reset_op");
    @(negedge clk);
  endtask

  task automatic test_random();
    bit w4;
    int gap;
    for (int n = 0; n < 24; n++) begin
      w4 = 1'($urandom);
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
      do_op(w4, 8'($urandom), 8'($urandom), 1'($urandom), w4 ? "rand_b4" : "rand_b1");
    end
    @(negedge clk);
  endtask

  task automatic test_overflow();
`ifdef SERIAL_ADDSUB_OVF_EN
    do_op(1'b0, 8'h7F, 8'h01, 1'b0, "ovf_7F_p_01");
    tests++;
    if (ovf1 !== 1'b1 || sum1 !== 8'h80) begin
      fails++;
      $display("FAIL ovf_7F_p_01 const: ovf=%b sum=%h, required 1/80", ovf1, sum1);
    end
    do_op(1'b0, 8'h80, 8'h01, 1'b1, "ovf_80_m_01");
    tests++;
    if (ovf1 !== 1'b1 || sum1 !== 8'h7F) begin
      fails++;
      $display("FAIL ovf_80_m_01 const: ovf=%b sum=%h, required 1/7F", ovf1, sum1);
    end
    do_op(1'b0, 8'h05, 8'h03, 1'b0, "ovf_05_p_03");
    tests++;
    if (ovf1 !== 1'b0) begin
      fails++;
      $display("FAIL ovf_05_p_03 const: ovf=%b, required 0", ovf1);
    end
    @(negedge clk);
`else
    @(negedge clk);
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    s1 = 1'b0; sub1 = 1'b0; a1 = 8'h00; b1 = 8'h00;
    s4 = 1'b0; sub4 = 1'b0; a4 = 8'h00; b4 = 8'h00;
    @(negedge clk);
    test_reset();
    test_add_directed();
    test_sub_back_to_back();
    test_bpc4();
    test_start_ignored();
    test_mid_reset();
    test_overflow();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
